// File: rtl/video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module  : video_timing_gen
// Purpose : Programmable video timing and frame-buffer address generator.
//           Divides master_clock into phi2, runs pixel/line counters, produces
//           registered syncs, blanking and scrolled {row, column} addresses,
//           and accepts serial commands (scroll, raster line, irq control).
// Ports   : master_clock  pixel-rate clock, all logic on its falling edge
//           not_reset     asynchronous active-low reset
//           boot          low = boot mode (scrolls held at 0, visible = 0)
//           shift_clock   serial command clock (asynchronous)
//           shift_data    serial command data (asynchronous)
//           shift_latch   rising edge executes the assembled command
//           phi2          master_clock / 2
//           hsync, vsync  active-low syncs
//           visible       high inside the active area
//           video_addr    {row, column} frame-buffer address
//           line          current line counter
//           irq_n         active-low interrupt request
// Revision: 1.0 - initial release
//==============================================================================
module video_timing_gen #(
  parameter int H_VISIBLE    = 320,
  parameter int H_SYNC_START = 328,
  parameter int H_SYNC_END   = 376,
  parameter int H_TOTAL      = 400,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525,
  parameter int COL_W        = 9,
  parameter int ADDR_W       = 19,
  parameter int SCROLL_W     = 8
) (
  input  logic              master_clock,
  input  logic              not_reset,
  input  logic              boot,
  input  logic              shift_clock,
  input  logic              shift_data,
  input  logic              shift_latch,
  output logic              phi2,
  output logic              hsync,
  output logic              vsync,
  output logic              visible,
  output logic [ADDR_W-1:0] video_addr,
  output logic [9:0]        line,
  output logic              irq_n
);

  localparam int c_row_w = ADDR_W - COL_W;
  localparam int c_pix_w = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;

  localparam logic [c_pix_w-1:0] c_pix_last = c_pix_w'(H_TOTAL - 1);
  localparam logic [c_pix_w-1:0] c_h_vis    = c_pix_w'(H_VISIBLE);
  localparam logic [c_pix_w-1:0] c_hs_start = c_pix_w'(H_SYNC_START);
  localparam logic [c_pix_w-1:0] c_hs_end   = c_pix_w'(H_SYNC_END);
  localparam logic [9:0]         c_lin_last = 10'(V_TOTAL - 1);
  localparam logic [9:0]         c_v_vis    = 10'(V_VISIBLE);
  localparam logic [9:0]         c_vs_start = 10'(V_SYNC_START);
  localparam logic [9:0]         c_vs_end   = 10'(V_SYNC_END);

  localparam logic [1:0] c_op_vscroll = 2'b00;
  localparam logic [1:0] c_op_hscroll = 2'b01;
  localparam logic [1:0] c_op_raster  = 2'b10;
  localparam logic [1:0] c_op_control = 2'b11;

  // Counters
  logic               phase_q;
  logic [c_pix_w-1:0] pixel_q, pixel_d;
  logic [9:0]         line_q, line_d;

  // Serial port: [0],[1] synchroniser stages, [2] previous value for edge detect
  logic [2:0]  sclk_q;
  logic [1:0]  sdat_q;
  logic [2:0]  slat_q;
  logic [11:0] shift_q, shift_d;

  // Command-controlled state
  logic [SCROLL_W-1:0] vscroll_q, vscroll_d;
  logic [SCROLL_W-1:0] hscroll_q, hscroll_d;
  logic [9:0]          raster_q, raster_d;
  logic                vs_en_q, vs_en_d, rs_en_q, rs_en_d;
  logic                vs_pend_q, vs_pend_d, rs_pend_q, rs_pend_d;

  // Registered outputs
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              visible_q, visible_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              irq_n_q, irq_n_d;

  logic               w_tick, w_new_line, w_exec, w_ack;
  logic [1:0]         w_op;
  logic [9:0]         w_val;
  logic [COL_W-1:0]   w_col;
  logic [c_row_w-1:0] w_row;

  // A pixel tick is the clock on which phase is low, i.e. phi2 is about to rise.
  assign w_tick     = ~phase_q;
  assign w_new_line = w_tick && (pixel_q == c_pix_last);

  assign w_op   = shift_q[11:10];
  assign w_val  = shift_q[9:0];
  assign w_exec = slat_q[1] & ~slat_q[2];

  always_comb begin
    pixel_d = pixel_q;
    line_d  = line_q;
    if (w_tick) begin
      if (pixel_q == c_pix_last) begin
        pixel_d = '0;
        line_d  = (line_q == c_lin_last) ? 10'd0 : line_q + 10'd1;
      end else begin
        pixel_d = pixel_q + 1'b1;
      end
    end
  end

  always_comb begin
    shift_d   = shift_q;
    vscroll_d = vscroll_q;
    hscroll_d = hscroll_q;
    raster_d  = raster_q;
    vs_en_d   = vs_en_q;
    rs_en_d   = rs_en_q;
    w_ack     = 1'b0;

    if (sclk_q[1] && !sclk_q[2]) begin
      shift_d = {shift_q[10:0], sdat_q[1]};
    end

    if (w_exec) begin
      case (w_op)
        c_op_vscroll: vscroll_d = w_val[SCROLL_W-1:0];
        c_op_hscroll: hscroll_d = w_val[SCROLL_W-1:0];
        c_op_raster:  raster_d  = w_val;
        c_op_control: begin
          vs_en_d = w_val[0];
          rs_en_d = w_val[1];
          w_ack   = w_val[2];
        end
        default: ;
      endcase
    end

    // Boot mode overrides any scroll write on the same clock.
    if (!boot) begin
      vscroll_d = '0;
      hscroll_d = '0;
    end
  end

  // Events are decoded from the next counter state so irq_n moves on the same
  // edge as the counter; a new event beats a simultaneous acknowledge.
  always_comb begin
    vs_pend_d = (w_new_line && (line_d == c_vs_start) && vs_en_q) ||
                (vs_pend_q && !w_ack);
    rs_pend_d = (w_new_line && (line_d == raster_q) && rs_en_q) ||
                (rs_pend_q && !w_ack);
    irq_n_d   = ~(vs_pend_d | rs_pend_d);
  end

  // Outputs describe the next counter state so they share its edge exactly.
  always_comb begin
    hsync_d   = ~((pixel_d >= c_hs_start) && (pixel_d < c_hs_end));
    vsync_d   = ~((line_d >= c_vs_start) && (line_d < c_vs_end));
    visible_d = boot && (pixel_d < c_h_vis) && (line_d < c_v_vis);
    w_col     = COL_W'(pixel_d) + COL_W'(hscroll_q);
    w_row     = c_row_w'(line_d) + c_row_w'({vscroll_q, 1'b0});
    addr_d    = {w_row, w_col};
  end

  always_ff @(negedge master_clock or negedge not_reset) begin
    if (!not_reset) begin
      phase_q   <= 1'b0;
      pixel_q   <= '0;
      line_q    <= '0;
      sclk_q    <= '0;
      sdat_q    <= '0;
      slat_q    <= '0;
      shift_q   <= '0;
      vscroll_q <= '0;
      hscroll_q <= '0;
      raster_q  <= '0;
      vs_en_q   <= 1'b0;
      rs_en_q   <= 1'b0;
      vs_pend_q <= 1'b0;
      rs_pend_q <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      visible_q <= 1'b0;
      addr_q    <= '0;
      irq_n_q   <= 1'b1;
    end else begin
      phase_q   <= ~phase_q;
      pixel_q   <= pixel_d;
      line_q    <= line_d;
      sclk_q    <= {sclk_q[1:0], shift_clock};
      sdat_q    <= {sdat_q[0], shift_data};
      slat_q    <= {slat_q[1:0], shift_latch};
      shift_q   <= shift_d;
      vscroll_q <= vscroll_d;
      hscroll_q <= hscroll_d;
      raster_q  <= raster_d;
      vs_en_q   <= vs_en_d;
      rs_en_q   <= rs_en_d;
      vs_pend_q <= vs_pend_d;
      rs_pend_q <= rs_pend_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      visible_q <= visible_d;
      addr_q    <= addr_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign phi2       = phase_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign visible    = visible_q;
  assign video_addr = addr_q;
  assign line       = line_q;
  assign irq_n      = irq_n_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module  : tb_video_timing_gen
// Purpose : Self-checking bench for video_timing_gen using reduced timing
//           parameters so several whole frames fit in a short run. Expected
//           outputs come from arithmetic on the number of clocks since reset.
// Revision: 1.0 - initial release
//==============================================================================
module tb_video_timing_gen;

  localparam int HV = 20, HSS = 22, HSE = 26, HT = 30;
  localparam int VV = 20, VSS = 23, VSE = 25, VT = 28;
  localparam int CW = 5, AW = 11, SW = 8, RW = AW - CW;

  logic          master_clock = 1'b0;
  logic          not_reset, boot, shift_clock, shift_data, shift_latch;
  logic          phi2, hsync, vsync, visible, irq_n;
  logic [AW-1:0] video_addr;
  logic [9:0]    line;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 master_clock = ~master_clock;

  video_timing_gen #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .COL_W(CW), .ADDR_W(AW), .SCROLL_W(SW)
  ) dut (
    .master_clock(master_clock), .not_reset(not_reset), .boot(boot),
    .shift_clock(shift_clock), .shift_data(shift_data), .shift_latch(shift_latch),
    .phi2(phi2), .hsync(hsync), .vsync(vsync), .visible(visible),
    .video_addr(video_addr), .line(line), .irq_n(irq_n)
  );

  // ---------------- reference model ----------------
  // n_m = active clock edges since reset release; ticks = ceil(n/2).
  int          n_m;
  int          vs_m, hs_m, rl_m, avs_m, ahs_m;
  bit          vs_en_m, rs_en_m, vs_pend_m, rs_pend_m, boot_m;
  int          cmd_edge_m;
  logic [11:0] cmd_word_m;
  logic        ex_m, ack_m;

  function automatic int tk(input int n);     return (n + 1) / 2;          endfunction
  function automatic int pix_of(input int n); return tk(n) % HT;           endfunction
  function automatic int lin_of(input int n); return (tk(n) / HT) % VT;    endfunction
  function automatic bit new_line(input int n);
    return (n % 2 == 1) && (tk(n) % HT == 0);
  endfunction

  assign ex_m  = (n_m + 1 == cmd_edge_m);
  assign ack_m = ex_m && (cmd_word_m[11:10] == 2'b11) && cmd_word_m[2];

  always @(negedge master_clock or negedge not_reset) begin
    if (!not_reset) begin
      n_m <= 0; vs_m <= 0; hs_m <= 0; rl_m <= 0; avs_m <= 0; ahs_m <= 0;
      vs_en_m <= 0; rs_en_m <= 0; vs_pend_m <= 0; rs_pend_m <= 0; boot_m <= 1;
    end else begin
      n_m    <= n_m + 1;
      boot_m <= boot;
      avs_m  <= vs_m;
      ahs_m  <= hs_m;
      if (!boot) begin
        vs_m <= 0; hs_m <= 0;
      end else if (ex_m && cmd_word_m[11:10] == 2'b00) begin
        vs_m <= int'(cmd_word_m[SW-1:0]);
      end else if (ex_m && cmd_word_m[11:10] == 2'b01) begin
        hs_m <= int'(cmd_word_m[SW-1:0]);
      end
      if (ex_m && cmd_word_m[11:10] == 2'b10) rl_m <= int'(cmd_word_m[9:0]);
      if (ex_m && cmd_word_m[11:10] == 2'b11) begin
        vs_en_m <= cmd_word_m[0];
        rs_en_m <= cmd_word_m[1];
      end
      vs_pend_m <= (new_line(n_m + 1) && lin_of(n_m + 1) == VSS && vs_en_m) ||
                   (vs_pend_m && !ack_m);
      rs_pend_m <= (new_line(n_m + 1) && lin_of(n_m + 1) == rl_m && rs_en_m) ||
                   (rs_pend_m && !ack_m);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int p = pix_of(n_m);
    int l = lin_of(n_m);
    int row = (l + 2 * avs_m) % (1 << RW);
    int col = (p + ahs_m) % (1 << CW);
    chk("phi2",    {31'd0, phi2},    n_m % 2);
    chk("hsync",   {31'd0, hsync},   (p >= HSS && p < HSE) ? 0 : 1);
    chk("vsync",   {31'd0, vsync},   (l >= VSS && l < VSE) ? 0 : 1);
    chk("visible", {31'd0, visible}, (n_m != 0 && boot_m && p < HV && l < VV) ? 1 : 0);
    chk("line",    {22'd0, line},    l);
    chk("addr",    {21'd0, video_addr}, row * (1 << CW) + col);
    chk("irq_n",   {31'd0, irq_n},   (vs_pend_m || rs_pend_m) ? 0 : 1);
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge master_clock);
      check_all();
    end
  endtask

  task automatic send_bits(input logic [11:0] w, input int nbits);
    for (int i = 11; i > 11 - nbits; i--) begin
      shift_data = w[i];
      cyc(2);
      shift_clock = 1'b1;
      cyc(3);
      shift_clock = 1'b0;
      cyc(2);
    end
  endtask

  task automatic latch(input logic [11:0] w);
    cmd_word_m  = w;
    cmd_edge_m  = n_m + 3;
    shift_latch = 1'b1;
    cyc(4);
    shift_latch = 1'b0;
    cyc(2);
  endtask

  task automatic send_cmd(input logic [11:0] w);
    send_bits(w, 12);
    latch(w);
  endtask

  task automatic wait_lp(input int l, input int p);
    int b = 0;
    while (!(lin_of(n_m) == l && pix_of(n_m) == p) && b < 4000) begin
      cyc(1);
      b++;
    end
    chk("wait_bound", {31'd0, (b < 4000)}, 1);
  endtask

  task automatic check_reset_values();
    chk("rst_phi2",    {31'd0, phi2},       0);
    chk("rst_hsync",   {31'd0, hsync},      1);
    chk("rst_vsync",   {31'd0, vsync},      1);
    chk("rst_visible", {31'd0, visible},    0);
    chk("rst_line",    {22'd0, line},       0);
    chk("rst_addr",    {21'd0, video_addr}, 0);
    chk("rst_irq_n",   {31'd0, irq_n},      1);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [11:0] w;
    int          t_e, n_target, b;

    not_reset = 1'b0; boot = 1'b1;
    shift_clock = 1'b0; shift_data = 1'b0; shift_latch = 1'b0;
    cmd_edge_m = 0; cmd_word_m = '0;

    repeat (3) @(posedge master_clock);
    check_reset_values();
    not_reset = 1'b1;

    // Free-running counters over more than one full frame.
    cyc(2 * HT * VT + 200);

    // Scroll: vscroll 3, hscroll 5 -> line 10 pixel 0 gives row 16, col 5.
    send_cmd({2'b00, 10'd3});
    send_cmd({2'b01, 10'd5});
    wait_lp(10, 0);
    chk("addr_l10_p0", {21'd0, video_addr}, 32'd517);
    // Column wrap: hscroll 30, pixel 5 -> (35 mod 32) = 3, row 12+6 = 18.
    send_cmd({2'b01, 10'd30});
    wait_lp(12, 5);
    chk("addr_col_wrap", {21'd0, video_addr}, 32'd579);

    // Raster irq at line 10, then acknowledge with 3-clock latency.
    send_cmd({2'b11, 10'b100});
    send_cmd({2'b10, 10'd10});
    send_cmd({2'b11, 10'b010});
    wait_lp(10, 0);
    chk("irq_raster", {31'd0, irq_n}, 0);
    w = {2'b11, 10'b110};
    send_bits(w, 12);
    cmd_word_m = w; cmd_edge_m = n_m + 3; shift_latch = 1'b1;
    cyc(2);
    chk("irq_before_ack", {31'd0, irq_n}, 0);
    cyc(1);
    chk("irq_after_ack", {31'd0, irq_n}, 1);
    shift_latch = 1'b0;
    cyc(2);

    // Both sources on the vsync line: a single assertion with two flags.
    send_cmd({2'b10, 10'(VSS)});
    send_cmd({2'b11, 10'b011});
    wait_lp(VSS, 0);
    chk("irq_both", {31'd0, irq_n}, 0);
    // Acknowledge lands on the edge of the next frame's vsync event.
    w = {2'b11, 10'b111};
    send_bits(w, 12);
    t_e      = ((tk(n_m) / (HT * VT)) + 1) * (HT * VT) + VSS * HT;
    n_target = 2 * t_e - 1;
    b = 0;
    while (n_m < n_target - 3 && b < 4000) begin
      cyc(1);
      b++;
    end
    chk("wait_event", {31'd0, (n_m == n_target - 3)}, 1);
    cmd_word_m = w; cmd_edge_m = n_m + 3; shift_latch = 1'b1;
    cyc(3);
    chk("irq_set_beats_ack", {31'd0, irq_n}, 0);
    shift_latch = 1'b0;
    cyc(2);
    send_cmd({2'b11, 10'b100});
    chk("irq_plain_ack", {31'd0, irq_n}, 1);

    // Randomized commands, raster lines (some beyond the frame) and boot.
    repeat (20) begin
      logic [1:0] op;
      logic [9:0] val;
      op = 2'($urandom_range(0, 3));
      case (op)
        2'b10:   val = 10'($urandom_range(0, VT + 3));
        2'b11:   val = 10'($urandom_range(0, 7));
        default: val = 10'($urandom_range(0, 1023));
      endcase
      boot = ($urandom_range(0, 4) != 0);
      send_cmd({op, val});
      cyc($urandom_range(10, 150));
    end
    boot = 1'b1;
    send_cmd({2'b11, 10'b100});

    // Boot mode: scroll writes ignored and scrolls forced to 0.
    send_cmd({2'b00, 10'd3});
    send_cmd({2'b01, 10'd4});
    boot = 1'b0;
    send_cmd({2'b00, 10'd7});
    chk("vis_boot", {31'd0, visible}, 0);
    boot = 1'b1;
    wait_lp(5, 0);
    chk("addr_after_boot", {21'd0, video_addr}, 32'd160);

    // Reset in the middle of a command with scroll and irq active.
    send_cmd({2'b00, 10'd9});
    send_cmd({2'b11, 10'b001});
    wait_lp(VSS, 1);
    chk("irq_pre_reset", {31'd0, irq_n}, 0);
    send_bits({2'b01, 10'd21}, 6);
    not_reset  = 1'b0;
    cmd_edge_m = 0;
    #1;
    check_reset_values();
    @(posedge master_clock);
    not_reset = 1'b1;
    cyc(200);
    send_cmd({2'b00, 10'd2});
    cyc(100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
